// File: rtl/matrix_scan_pkg.sv
// Shared types and helpers for the LED matrix row scanner and the frame generator.
// Row 0 occupies the most significant COLS bits of a packed frame.
package matrix_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_t;

  // Width able to hold 0..n-1, never narrower than one bit.
  function automatic int sel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // LSB position of row r inside a packed rows*cols frame.
  function automatic int row_lsb(input int rows, input int cols, input int r);
    return (rows - 1 - r) * cols;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Row-period divider: counts 0..DIV-1 with synchronous clear, flags the last
// cycle of the period and the cycle after which blanking begins.
module scan_prescaler
  import matrix_scan_pkg::*;
#(
  parameter int DIV   = 4,
  parameter int BLANK = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic period_end,
  output logic blank_start
);

  localparam int CW = sel_w(DIV);
  localparam logic [CW-1:0] LAST     = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_AT = CW'(DIV - BLANK - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (count_reg == LAST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign period_end  = (count_reg == LAST);
  assign blank_start = (count_reg == BLANK_AT);

endmodule

// File: rtl/matrix_row_scanner.sv
// Free-running, double-buffered LED matrix row scanner with registered outputs.
// Define ROW_SCAN_BLANK_EN to insert BLANK dark cycles at the end of every row period.
module matrix_row_scanner
  import matrix_scan_pkg::*;
#(
  parameter int ROWS  = 7,
  parameter int COLS  = 5,
  parameter int DIV   = 4,
  parameter int BLANK = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      load,
  input  logic [ROWS*COLS-1:0]      frame_in,
  output logic [sel_w(ROWS)-1:0]    row_sel,
  output logic [ROWS-1:0]           row_onehot,
  output logic [COLS-1:0]           col_out,
  output logic                      frame_done,
  output logic                      load_ack
);

  localparam int RW  = sel_w(ROWS);
  localparam int FW  = ROWS * COLS;
  localparam int FBW = sel_w(FW);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  scan_state_t   state_reg, state_next;
  logic [RW-1:0] row_reg, row_next;
  logic [FW-1:0] active_reg, active_next;
  logic [FW-1:0] pending_reg, pending_next;
  logic          pending_flag_reg, pending_flag_next;
  logic          advance, boundary, ack_next, drive_next;
  logic          period_end, blank_start;
  logic [FBW-1:0] col_base;

  scan_prescaler #(
    .DIV   (DIV),
    .BLANK (BLANK)
  ) u_prescaler (
    .clk         (clk),
    .rst         (rst),
    .clr         ((state_reg == ST_IDLE) || !en),
    .period_end  (period_end),
    .blank_start (blank_start)
  );

`ifndef ROW_SCAN_BLANK_EN
  logic unused_blank;
  assign unused_blank = blank_start;
`endif

  always_comb begin
    state_next        = state_reg;
    row_next          = row_reg;
    active_next       = active_reg;
    pending_next      = pending_reg;
    pending_flag_next = pending_flag_reg;
    advance           = 1'b0;
    boundary          = 1'b0;
    ack_next          = 1'b0;

    if (load) begin
      pending_next      = frame_in;
      pending_flag_next = 1'b1;
    end

    if (!en && state_reg != ST_IDLE) begin
      state_next = ST_IDLE;
      row_next   = '0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (en) begin
            state_next = ST_DRIVE;
            row_next   = '0;
          end else if (pending_flag_reg) begin
            // A load in this same cycle stays pending for the following edge.
            active_next       = pending_reg;
            pending_flag_next = load;
            ack_next          = 1'b1;
          end
        end
        ST_DRIVE: begin
`ifdef ROW_SCAN_BLANK_EN
          if (blank_start) begin
            state_next = ST_BLANK;
          end
`else
          if (period_end) begin
            advance = 1'b1;
          end
`endif
        end
`ifdef ROW_SCAN_BLANK_EN
        ST_BLANK: begin
          if (period_end) begin
            state_next = ST_DRIVE;
            advance    = 1'b1;
          end
        end
`endif
        default: state_next = ST_IDLE;
      endcase
    end

    // Frame swaps happen only on the wrap edge; a coincident load wins over pending.
    if (advance) begin
      if (row_reg == ROW_LAST) begin
        row_next = '0;
        boundary = 1'b1;
        if (load) begin
          active_next       = frame_in;
          pending_flag_next = 1'b0;
          ack_next          = 1'b1;
        end else if (pending_flag_reg) begin
          active_next       = pending_reg;
          pending_flag_next = 1'b0;
          ack_next          = 1'b1;
        end
      end else begin
        row_next = row_reg + RW'(1);
      end
    end
  end

  assign drive_next = (state_next == ST_DRIVE);
  assign col_base   = FBW'(row_lsb(ROWS, COLS, int'(row_next)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      row_reg          <= '0;
      active_reg       <= '0;
      pending_reg      <= '0;
      pending_flag_reg <= 1'b0;
      row_sel          <= '0;
      row_onehot       <= '0;
      col_out          <= '0;
      frame_done       <= 1'b0;
      load_ack         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      row_reg          <= row_next;
      active_reg       <= active_next;
      pending_reg      <= pending_next;
      pending_flag_reg <= pending_flag_next;
      row_sel          <= row_next;
      row_onehot       <= drive_next ? (ROWS'(1) << row_next) : '0;
      col_out          <= drive_next ? active_next[col_base +: COLS] : '0;
      frame_done       <= boundary;
      load_ack         <= ack_next;
    end
  end

endmodule

// File: tb/tb_matrix_row_scanner.sv
// Scoreboard bench for matrix_row_scanner: stimulus pushes the expected output
// of every cycle, a negedge monitor pops and compares.
module tb_matrix_row_scanner;

  localparam int ROWS  = 7;
  localparam int COLS  = 5;
  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int N     = ROWS * COLS;
  localparam int FRAME = ROWS * DIV;
`ifdef ROW_SCAN_BLANK_EN
  localparam int DRV = DIV - BLANK;
`else
  localparam int DRV = DIV;
`endif

  localparam logic [N-1:0] CHECK = 35'b10101_01010_10101_01010_10101_01010_10101;
  localparam logic [N-1:0] FA    = 35'h1;
  localparam logic [N-1:0] FB    = 35'h2;
  localparam logic [N-1:0] FR    = {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7};

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b0;
  logic            load = 1'b0;
  logic [N-1:0]    frame_in = '0;
  logic [2:0]      row_sel;
  logic [ROWS-1:0] row_onehot;
  logic [COLS-1:0] col_out;
  logic            frame_done;
  logic            load_ack;

  matrix_row_scanner #(
    .ROWS(ROWS), .COLS(COLS), .DIV(DIV), .BLANK(BLANK)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .frame_in(frame_in),
    .row_sel(row_sel), .row_onehot(row_onehot), .col_out(col_out),
    .frame_done(frame_done), .load_ack(load_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           tag;
    logic [2:0]      row;
    logic [ROWS-1:0] oh;
    logic [COLS-1:0] col;
    logic            done;
    logic            ack;
  } exp_t;

  exp_t         sb[$];
  int           n_tests = 0;
  int           n_fail = 0;
  int           k = -1;          // cycles since the enabling edge, -1 when idle
  logic [N-1:0] exp_frame = '0;  // frame the panel should be showing
  string        tag = "reset";

  task automatic run_cycle(input logic en_v, input logic ld, input logic [N-1:0] fr,
                           input logic ack_e);
    exp_t e;
    int r;
    logic [5:0] base;
    en = en_v;
    load = ld;
    frame_in = fr;
    @(posedge clk);
    if (en_v && !rst) k = k + 1;
    else k = -1;
    e.tag = tag;
    e.ack = ack_e;
    if (k < 0) begin
      e.row = '0; e.oh = '0; e.col = '0; e.done = 1'b0;
    end else begin
      r = (k / DIV) % ROWS;
      base = 6'((ROWS - 1 - r) * COLS);
      e.row = 3'(r);
      if ((k % DIV) < DRV) begin
        e.oh  = ROWS'(1) << r;
        e.col = exp_frame[base +: COLS];
      end else begin
        e.oh  = '0;
        e.col = '0;
      end
      e.done = (k > 0) && (k % FRAME == 0);
    end
    sb.push_back(e);
    #1;
    load = 1'b0;
  endtask

  task automatic run_until(input int phase);
    do run_cycle(1'b1, 1'b0, '0, 1'b0); while (k % FRAME != phase);
  endtask

  task automatic run_to_wrap(input logic ack_e, input logic [N-1:0] nf);
    while ((k + 1) % FRAME != 0) run_cycle(1'b1, 1'b0, '0, 1'b0);
    if (ack_e) exp_frame = nf;
    run_cycle(1'b1, 1'b0, '0, ack_e);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        n_tests++;
        if (row_sel !== e.row || row_onehot !== e.oh || col_out !== e.col ||
            frame_done !== e.done || load_ack !== e.ack) begin
          n_fail++;
          $display("FAIL %s: got row_sel=%0d onehot=%b col=%b done=%b ack=%b, required row_sel=%0d onehot=%b col=%b done=%b ack=%b",
                   e.tag, row_sel, row_onehot, col_out, frame_done, load_ack,
                   e.row, e.oh, e.col, e.done, e.ack);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) run_cycle(1'b0, 1'b0, '0, 1'b0);
    rst = 1'b0;
    tag = "idle";
    repeat (2) run_cycle(1'b0, 1'b0, '0, 1'b0);

    tag = "scan_zero";
    repeat (60) run_cycle(1'b1, 1'b0, '0, 1'b0);

    tag = "load_row3";
    run_until(12);
    run_cycle(1'b1, 1'b1, CHECK, 1'b0);
    run_to_wrap(1'b1, CHECK);
    repeat (10) run_cycle(1'b1, 1'b0, '0, 1'b0);

    tag = "two_loads";
    run_until(3);
    run_cycle(1'b1, 1'b1, FA, 1'b0);
    repeat (5) run_cycle(1'b1, 1'b0, '0, 1'b0);
    run_cycle(1'b1, 1'b1, FB, 1'b0);
    run_to_wrap(1'b1, FB);
    repeat (28) run_cycle(1'b1, 1'b0, '0, 1'b0);

    tag = "load_on_wrap";
    run_cycle(1'b1, 1'b1, FA, 1'b0);
    run_until(27);
    exp_frame = FR;
    run_cycle(1'b1, 1'b1, FR, 1'b1);
    repeat (8) run_cycle(1'b1, 1'b0, '0, 1'b0);
    run_to_wrap(1'b0, '0);
    repeat (4) run_cycle(1'b1, 1'b0, '0, 1'b0);

    tag = "en_drop";
    run_until(17);
    run_cycle(1'b0, 1'b0, '0, 1'b0);
    repeat (2) run_cycle(1'b0, 1'b0, '0, 1'b0);
    tag = "reenable";
    repeat (12) run_cycle(1'b1, 1'b0, '0, 1'b0);

    tag = "idle_load";
    run_cycle(1'b0, 1'b0, '0, 1'b0);
    run_cycle(1'b0, 1'b1, CHECK, 1'b0);
    exp_frame = CHECK;
    run_cycle(1'b0, 1'b0, '0, 1'b1);
    run_cycle(1'b0, 1'b0, '0, 1'b0);
    tag = "idle_load_scan";
    repeat (8) run_cycle(1'b1, 1'b0, '0, 1'b0);

    tag = "rst_mid";
    run_cycle(1'b1, 1'b1, FA, 1'b0);
    repeat (3) run_cycle(1'b1, 1'b0, '0, 1'b0);
    rst = 1'b1;
    exp_frame = '0;
    run_cycle(1'b1, 1'b0, '0, 1'b0);
    rst = 1'b0;
    tag = "after_rst";
    repeat (30) run_cycle(1'b1, 1'b0, '0, 1'b0);

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d unchecked entries, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_row_scanner.md
# matrix_row_scanner

Parametrised, time-multiplexed row scanner for the LED dot-matrix display panel. It replaces static per-row selection with a free-running scan. A row counter steps through ROWS rows, and each row is held for DIV clock cycles. For the row in focus, the block drives a one-hot row enable and that row's COLS column bits. Frames are double-buffered: a new frame is staged at any time and swapped in only at a frame boundary. It sits between the frame generator (character/pattern logic) and the panel pin drivers.

## Interface
- ROWS, 7, number of matrix rows (2..16)
- COLS, 5, number of matrix columns (1..32)
- DIV, 4, clock cycles per row period (≥2)
- BLANK, 1, blanking cycles at end of each row period (1..DIV-1); used only with ROW_SCAN_BLANK_EN
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  scan enable; low forces idle
- load  input  1  one-cycle strobe: stage frame_in as next frame
- frame_in  input  ROWS*COLS  frame data; row r = bits [(ROWS-r)*COLS-1 -: COLS] (row 0 is the MSB slice)
- row_sel  output  clog2(ROWS)  index of the row currently in its period
- row_onehot  output  ROWS  row drive, bit r high while row r is driven
- col_out  output  COLS  column data of the driven row, zero when not driving
- frame_done  output  1  one-cycle pulse after each row wrap ROWS-1→0
- load_ack  output  1  one-cycle pulse when a staged frame became active

## Operation
- States: IDLE, DRIVE, BLANK (BLANK exists only with ROW_SCAN_BLANK_EN).
- Reset: state IDLE; row_sel=0, row_onehot=0, col_out=0, frame_done=0, load_ack=0; active and pending frames = 0; pending flag = 0; div counter = 0.
- IDLE, en=0:
  - row_onehot=0 and col_out=0; row and div counters are held at 0.
  - A pending frame is copied to active on the next edge, and load_ack pulses.
- IDLE→DRIVE: on the edge where en=1 is sampled, starting at row 0 with div=0.
- DRIVE:
  - row_onehot = 1<<row_sel.
  - col_out = the active frame slice for row_sel.
  - The div counter increments each cycle.
- DRIVE→BLANK: when div = DIV-BLANK-1.
- BLANK:
  - row_onehot=0 and col_out=0.
  - At div = DIV-1, div is set to 0, the row advances (wrapping ROWS-1→0), and the state returns to DRIVE.
- Without blanking, DRIVE holds the full DIV cycles and then advances the row directly.
- en=0 in any state → IDLE on the next edge; counters are cleared and the outputs blank.
- load:
  - On the edge where load=1, frame_in is captured into the pending register and the pending flag is set.
  - If a second load arrives before the swap, it overwrites the pending frame (latest wins).
- Swap at frame boundary (the edge where the row wraps ROWS-1→0):
  - If the pending flag is set, active ← pending, the flag is cleared, and load_ack=1 for the next cycle.
  - frame_done=1 for the next cycle unconditionally.
- load coincident with the boundary edge:
  - frame_in bypasses the pending register straight to active, the flag is cleared, and load_ack pulses.
  - The previously pending frame is discarded.
- Row data changes only at frame boundaries, never mid-frame.

## Timing
- All outputs are registered.
- First drive is one cycle after en is sampled high.
- Row period is exactly DIV cycles. With blanking, each row is driven for DIV-BLANK cycles, then blanked for BLANK cycles.
- Frame period is ROWS*DIV cycles.
- Latency from load to visible data:
  - Minimum: 1 cycle if the load coincides with the boundary.
  - Maximum: ROWS*DIV cycles plus 1.
- rst mid-frame: all state returns to reset values on that edge; pending data is lost.
- rst dominates en and load.

## Configuration
- Macro `ROW_SCAN_BLANK_EN`.
- Defined: the BLANK state and BLANK parameter are active, giving an anti-ghosting gap after every row.
- Undefined:
  - No BLANK state; BLANK is ignored.
  - Rows are driven for the full DIV cycles, back-to-back.
  - Between consecutive rows there are no cycles with row_onehot=0 while en=1.

## Structure
- Package matrix_scan_pkg holds:
  - the state enum (IDLE, DRIVE, BLANK);
  - the clog2-based width constant helpers;
  - the row-slice index function shared with the frame generator.
- One sub-module, scan_prescaler: the DIV counter with sync clear. It outputs the end-of-period tick and the enter-blank tick.
- The FSM, row counter and frame buffers live in the top module.

## Test plan
All scenarios use ROWS=7, COLS=5, DIV=4, BLANK=1.
- Reset, then en=1 with a pending all-zeros frame:
  - row_onehot = 7'b0000001 for 3 cycles, then 0 for 1 cycle;
  - then row 1 follows;
  - frame_done pulses every 28 cycles.
- Load a checkerboard while scanning row 3:
  - col_out stays at the old data until the wrap;
  - load_ack and frame_done pulse together;
  - row 0 col_out = 5'b10101.
- Two loads (0x1 then 0x2) within one frame: only the second frame appears; a single load_ack.
- Load on the exact wrap edge: the new data is visible on row 0 in the following cycle; load_ack is 1.
- Drop en mid-row 4: the next cycle shows outputs 0 and row_sel=0; re-enable restarts at row 0.
- Build without ROW_SCAN_BLANK_EN: row_onehot is never 0 during an enabled scan; each row is held 4 cycles.
